// File: rtl/dfe_pam4_ntap.sv
// dfe_pam4_ntap: N-tap decision-feedback equalizer with a PAM4 slicer.
// Define DFE_LMS_ADAPT_EN to enable sign-sign LMS tap adaptation.
module dfe_pam4_ntap #(
  parameter int NUM_TAPS          = 4,
  parameter int SIG_W             = 16,
  parameter int COEF_W            = 8,
  parameter int COEF_FRAC         = 6,
  parameter int SYMBOL_SEPARATION = 56,
  parameter int MU_STEP           = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic signed [SIG_W-1:0]  in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     coef_wr_en,
  input  logic [2:0]               coef_wr_addr,
  input  logic signed [COEF_W-1:0] coef_wr_data,
  output logic signed [SIG_W-1:0]  out_level,
  output logic [1:0]               out_symbol,
  output logic signed [SIG_W-1:0]  out_err,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int ACC_W = SIG_W + COEF_W + 4;

`ifdef DFE_LMS_ADAPT_EN
  localparam bit LMS_EN = 1'b1;
`else
  localparam bit LMS_EN = 1'b0;
`endif

  localparam logic signed [ACC_W:0] SMAX =
    {{(ACC_W-SIG_W+2){1'b0}}, {(SIG_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN =
    {{(ACC_W-SIG_W+2){1'b1}}, {(SIG_W-1){1'b0}}};

  localparam int CMAX = (2 ** (COEF_W - 1)) - 1;
  localparam int CMIN = -(2 ** (COEF_W - 1));

  localparam logic signed [SIG_W-1:0] LV_P3 =
    SIG_W'(3 * SYMBOL_SEPARATION / 2);
  localparam logic signed [SIG_W-1:0] LV_P1 =
    SIG_W'(SYMBOL_SEPARATION / 2);
  localparam logic signed [SIG_W-1:0] LV_N1 =
    SIG_W'(-(SYMBOL_SEPARATION / 2));
  localparam logic signed [SIG_W-1:0] LV_N3 =
    SIG_W'(-(3 * SYMBOL_SEPARATION / 2));
  localparam logic signed [SIG_W-1:0] TH_P =
    SIG_W'(SYMBOL_SEPARATION);
  localparam logic signed [SIG_W-1:0] TH_Z = '0;
  localparam logic signed [SIG_W-1:0] TH_N =
    SIG_W'(-SYMBOL_SEPARATION);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DEC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [SIG_W-1:0]  x_q, x_d;
  logic signed [SIG_W-1:0]  eq_q, eq_d;
  logic signed [SIG_W-1:0]  hist_q [NUM_TAPS];
  logic signed [SIG_W-1:0]  hist_d [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_d [NUM_TAPS];
  logic signed [SIG_W-1:0]  level_q, level_d;
  logic [1:0]               sym_q, sym_d;
  logic signed [SIG_W-1:0]  err_q, err_d;
  logic                     valid_q, valid_d;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    diff;
  logic signed [SIG_W-1:0]  lvl_s;
  logic [1:0]               sym_s;
  logic signed [SIG_W-1:0]  err_s;

  function automatic logic signed [SIG_W-1:0] sat_sig(
    input logic signed [ACC_W:0] v
  );
    if (v > SMAX) begin
      return SMAX[SIG_W-1:0];
    end else if (v < SMIN) begin
      return SMIN[SIG_W-1:0];
    end
    return v[SIG_W-1:0];
  endfunction

  function automatic logic signed [COEF_W-1:0] sat_coef(
    input int v
  );
    if (v > CMAX) begin
      return COEF_W'(CMAX);
    end else if (v < CMIN) begin
      return COEF_W'(CMIN);
    end
    return COEF_W'(v);
  endfunction

  // Full-precision feedback sum; arithmetic shift drops the fraction.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc = acc + (ACC_W'(coef_q[k]) * ACC_W'(hist_q[k]));
    end
    diff = (ACC_W+1)'(x_q) - (ACC_W+1)'(acc >>> COEF_FRAC);
  end

  always_comb begin
    lvl_s = LV_N3;
    sym_s = 2'b00;
    if (eq_q >= TH_P) begin
      lvl_s = LV_P3;
      sym_s = 2'b10;
    end else if (eq_q >= TH_Z) begin
      lvl_s = LV_P1;
      sym_s = 2'b11;
    end else if (eq_q >= TH_N) begin
      lvl_s = LV_N1;
      sym_s = 2'b01;
    end
    err_s = eq_q - lvl_s;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    eq_d    = eq_q;
    hist_d  = hist_q;
    coef_d  = coef_q;
    level_d = level_q;
    sym_d   = sym_q;
    err_d   = err_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          state_d = ACC;
        end
      end
      ACC: begin
        eq_d    = sat_sig(diff);
        state_d = DEC;
      end
      DEC: begin
        level_d   = lvl_s;
        sym_d     = sym_s;
        err_d     = err_s;
        valid_d   = 1'b1;
        hist_d[0] = lvl_s;
        for (int k = 1; k < NUM_TAPS; k++) begin
          hist_d[k] = hist_q[k-1];
        end
        // Sign-sign update uses the history before the shift.
        if (LMS_EN) begin
          for (int k = 0; k < NUM_TAPS; k++) begin
            if (err_s != 0 && hist_q[k] != 0) begin
              coef_d[k] = sat_coef(int'(coef_q[k]) +
                ((err_s[SIG_W-1] ^ hist_q[k][SIG_W-1]) ?
                 -MU_STEP : MU_STEP));
            end
          end
        end
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Host writes land last so they override adaptation.
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (coef_wr_en && coef_wr_addr == 3'(k)) begin
        coef_d[k] = coef_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      x_q     <= '0;
      eq_q    <= '0;
      level_q <= '0;
      sym_q   <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        hist_q[k] <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      eq_q    <= eq_d;
      level_q <= level_d;
      sym_q   <= sym_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      hist_q  <= hist_d;
      coef_q  <= coef_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_level  = level_q;
  assign out_symbol = sym_q;
  assign out_err    = err_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_dfe_pam4_ntap.sv
// tb_dfe_pam4_ntap: directed checks of the PAM4 DFE with
// hand-computed levels, symbols and errors.
module tb_dfe_pam4_ntap;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               coef_wr_en = 1'b0;
  logic [2:0]         coef_wr_addr = '0;
  logic signed [7:0]  coef_wr_data = '0;
  logic signed [15:0] out_level;
  logic [1:0]         out_symbol;
  logic signed [15:0] out_err;
  logic               out_valid;
  logic               out_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  dfe_pam4_ntap dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .out_level    (out_level),
    .out_symbol   (out_symbol),
    .out_err      (out_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input logic [2:0] a,
                         input logic signed [7:0] d);
    coef_wr_en   = 1'b1;
    coef_wr_addr = a;
    coef_wr_data = d;
    tick();
    coef_wr_en = 1'b0;
  endtask

  // Accept one sample, check 2-edge latency and the decision.
  task automatic send(input string tag, input int din,
                      input int lvl, input int sym, input int err,
                      input bit acc_wr, input logic signed [7:0] acc_d);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = 16'(din);
    tick();
    in_valid = 1'b0;
    if (acc_wr) begin
      coef_wr_en   = 1'b1;
      coef_wr_addr = 3'd0;
      coef_wr_data = acc_d;
    end
    check({tag, "_v1"}, out_valid, 0);
    tick();
    coef_wr_en = 1'b0;
    check({tag, "_v2"}, out_valid, 0);
    tick();
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_lvl"}, out_level, lvl);
    check({tag, "_sym"}, out_symbol, sym);
    check({tag, "_err"}, out_err, err);
    if (out_ready) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst_vld", out_valid, 0);
    check("rst_rdy", in_ready, 1);
    check("rst_lvl", out_level, 0);
    check("rst_sym", out_symbol, 0);
    check("rst_err", out_err, 0);
    rstn = 1'b1;
    tick();

    send("s30",   30,  28, 2'b11,   2, 0, 0);
    send("s56",   56,  84, 2'b10, -28, 0, 0);
    send("s0",     0,  28, 2'b11, -28, 0, 0);
    send("sm56", -56, -28, 2'b01, -28, 0, 0);
    send("sm57", -57, -84, 2'b00,  27, 0, 0);
    send("s55",   55,  28, 2'b11,  27, 0, 0);

    wr_coef(3'd4, 8'sd64);
    send("badaddr", 56, 84, 2'b10, -28, 0, 0);
    send("accwr", 30, 28, 2'b11, 2, 1, 8'sd64);
    send("c64a",   0, -28, 2'b01,  0, 0, 0);
    send("c64b", 100,  84, 2'b10, 44, 0, 0);
    send("c64c", 112,  28, 2'b11,  0, 0, 0);
    send("c64d", 100,  84, 2'b10, -12, 0, 0);

    wr_coef(3'd0, -8'sd128);
    send("satp", 32767, 84, 2'b10, 32683, 0, 0);
    wr_coef(3'd0, 8'sd64);
    send("satn", -32768, -84, 2'b00, -32684, 0, 0);

    wr_coef(3'd0, 8'sd0);
    out_ready = 1'b0;
    send("hold", 30, 28, 2'b11, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_vld", out_valid, 1);
      check("hold_lvl", out_level, 28);
      check("hold_sym", out_symbol, 2'b11);
      check("hold_err", out_err, 2);
      check("hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("rel_vld", out_valid, 0);
    check("rel_rdy", in_ready, 1);

    wr_coef(3'd0, 8'sd64);
    wr_coef(3'd3, -8'sd5);
    in_valid = 1'b1;
    in_data  = 16'sd30;
    tick();
    in_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    check("mrst_vld", out_valid, 0);
    tick();
    rstn = 1'b1;
    check("mrst_vld2", out_valid, 0);
    check("mrst_rdy", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mrst_hist%0d", k), dut.hist_q[k], 0);
      check($sformatf("mrst_coef%0d", k), dut.coef_q[k], 0);
    end
    tick();
    send("post30", 30, 28, 2'b11,   2, 0, 0);
    send("post0",   0, 28, 2'b11, -28, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
